// File: rtl/hams_pkg.sv
// Shared types and constants for the HAMS merge scheduler.
package hams_pkg;

    localparam int HAMS_KEY_W = 32;

    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } hams_merge_st_e;

endpackage

// File: rtl/hams_merge_outreg.sv
// Single-entry valid/ready output register holding a key and its last flag.
module hams_merge_outreg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              rdy_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // A load always wins; otherwise an accepted entry empties the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
            last_q <= last_i;
        end else if (rdy_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign last_o = last_q;

endmodule

// File: rtl/hams_merge_sched.sv
// Two-way merge scheduler: merges two sorted runs of RUN_LEN keys into one run.
// Define HAMS_MERGE_DESC_EN to merge descending runs instead of ascending ones.
module hams_merge_sched
    import hams_pkg::*;
#(
    parameter int DATA_W  = HAMS_KEY_W,
    parameter int RUN_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_vld,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_rdy,
    input  logic              b_vld,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_rdy,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              o_rdy,
    output logic [15:0]       run_cnt,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(RUN_LEN + 1);
    localparam logic [CNT_W-1:0] RUN_END = CNT_W'(RUN_LEN);

    // Handshake: a key moves on a stream when vld && rdy at a rising edge.
    // rdy is a combinational function of vld, o_rdy and the output register.

    hams_merge_st_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic [15:0]       run_cnt_q, run_cnt_d;

    logic              out_free;
    logic              sel_a;
    logic              a_xfer;
    logic              b_xfer;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic [CNT_W-1:0]  cnt_a_inc;
    logic [CNT_W-1:0]  cnt_b_inc;

    assign out_free  = !o_vld || o_rdy;
    assign cnt_a_inc = cnt_a_q + CNT_W'(1);
    assign cnt_b_inc = cnt_b_q + CNT_W'(1);

`ifdef HAMS_MERGE_DESC_EN
    assign sel_a = (a_data >= b_data);
`else
    assign sel_a = (a_data <= b_data);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        run_cnt_d = run_cnt_q;
        a_rdy     = 1'b0;
        b_rdy     = 1'b0;
        a_xfer    = 1'b0;
        b_xfer    = 1'b0;
        load      = 1'b0;
        load_data = a_data;
        load_last = 1'b0;

        case (state_q)
            MERGE: begin
                if (out_free && a_vld && b_vld) begin
                    a_rdy = sel_a;
                    b_rdy = !sel_a;
                end
            end
            DRAIN_A: a_rdy = out_free;
            DRAIN_B: b_rdy = out_free;
            default: ;
        endcase

        // Nothing is offered while the block is held in reset.
        if (!rst_n) begin
            a_rdy = 1'b0;
            b_rdy = 1'b0;
        end

        a_xfer = a_vld && a_rdy;
        b_xfer = b_vld && b_rdy;

        if (a_xfer) begin
            cnt_a_d   = cnt_a_inc;
            load      = 1'b1;
            load_data = a_data;
        end
        if (b_xfer) begin
            cnt_b_d   = cnt_b_inc;
            load      = 1'b1;
            load_data = b_data;
        end

        case (state_q)
            MERGE: begin
                if (a_xfer && cnt_a_inc == RUN_END) state_d = DRAIN_B;
                if (b_xfer && cnt_b_inc == RUN_END) state_d = DRAIN_A;
            end
            DRAIN_A: begin
                if (a_xfer && cnt_a_inc == RUN_END) begin
                    state_d   = MERGE;
                    cnt_a_d   = '0;
                    cnt_b_d   = '0;
                    run_cnt_d = run_cnt_q + 16'd1;
                    load_last = 1'b1;
                end
            end
            DRAIN_B: begin
                if (b_xfer && cnt_b_inc == RUN_END) begin
                    state_d   = MERGE;
                    cnt_a_d   = '0;
                    cnt_b_d   = '0;
                    run_cnt_d = run_cnt_q + 16'd1;
                    load_last = 1'b1;
                end
            end
            default: state_d = MERGE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MERGE;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    hams_merge_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .data_i (load_data),
        .last_i (load_last),
        .rdy_i  (o_rdy),
        .vld_o  (o_vld),
        .data_o (o_data),
        .last_o (o_last)
    );

    assign run_cnt     = run_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/hams_merge_sched.md
# hams_merge_sched

Two-way merge scheduler for the HAMS sort datapath. It accepts two ascending-sorted runs of RUN_LEN keys each, on independent valid/ready streams A and B, and emits one merged run of 2*RUN_LEN keys through a registered output stage. It sequences the merge/drain phases and arbitrates which input stream feeds the output on each cycle. Run pairs are processed back-to-back without software intervention.

## Interface
- DATA_W, 32, key width in bits
- RUN_LEN, 4, keys per input run; any value ≥1
- CNT_W, $clog2(RUN_LEN+1), localparam; width of the per-stream counters
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a_vld  in  1  stream A key valid
- a_data  in  DATA_W  stream A key
- a_rdy  out  1  stream A key consumed this cycle
- b_vld  in  1  stream B key valid
- b_data  in  DATA_W  stream B key
- b_rdy  out  1  stream B key consumed this cycle
- o_vld  out  1  merged key valid
- o_data  out  DATA_W  merged key
- o_last  out  1  marks the final (2*RUN_LEN-th) key of a merged run
- o_rdy  in  1  downstream accepts o_data
- run_cnt  out  16  completed merged runs; wraps at 2^16

## Operation
- Transfer on a stream occurs when vld && rdy are high at a rising edge.
- out_free = !o_vld || o_rdy; no input is consumed unless out_free.
- Counters: cnt_a and cnt_b (CNT_W bits) count keys consumed from A and B in the current run pair.
- States: MERGE, DRAIN_A, DRAIN_B.
  - MERGE: arbitration requires a_vld && b_vld. sel_a = (a_data ≤ b_data), unsigned. a_rdy = out_free && a_vld && b_vld && sel_a; b_rdy = out_free && a_vld && b_vld && !sel_a. If only one stream is valid, nothing is consumed. Ties take A.
  - MERGE → DRAIN_B when an A transfer makes cnt_a == RUN_LEN. MERGE → DRAIN_A when a B transfer makes cnt_b == RUN_LEN.
  - DRAIN_A: a_rdy = out_free; b_rdy = 0. DRAIN_B mirrors this with the streams swapped. No comparison is made in either drain state.
  - The drain state ends when its counter reaches RUN_LEN. At that point both counters clear, state returns to MERGE and run_cnt increments. This all happens on the same edge as the final input transfer.
- Output register: loads the selected key on any input transfer. o_last is set when the transfer is the 2*RUN_LEN-th key of the pair. o_vld is cleared when o_rdy is high and there is no new load.
- RUN_LEN = 1: MERGE always goes directly to one drain state, and the pair completes after exactly 2 transfers.
- Input data is not checked for sortedness. Unsorted runs produce deterministic but unspecified order.

## Timing
- Reset values: o_vld=0, o_data=0, o_last=0, run_cnt=0, state=MERGE, cnt_a=cnt_b=0. a_rdy and b_rdy are 0 while in reset.
- Latency: a key accepted at edge N appears on o_data and o_vld after edge N, i.e. 1 cycle.
- Throughput: 1 key per cycle while the output is drained every cycle.
- a_rdy and b_rdy combinationally depend on a_vld, b_vld and o_rdy. Upstream must not derive vld from rdy.
- Backpressure: with o_rdy=0 and o_vld=1, o_data and o_last hold and both rdy outputs are 0.
- Reset mid-run discards the partial pair. After release, the first accepted keys start a fresh pair.

## Configuration
- HAMS_MERGE_DESC_EN defined: descending merge. sel_a = (a_data ≥ b_data), ties still take A; inputs must be descending.
- Not defined: ascending merge as described above.

## Structure
- hams_pkg contains:
  - typedef enum logic [1:0] hams_merge_st_e {MERGE, DRAIN_A, DRAIN_B}
  - default DATA_W constant HAMS_KEY_W = 32
- Sub-module hams_merge_outreg: single valid/ready output register holding data and last, with load/clear control. It is instantiated once.

## Test plan
- RUN_LEN=4, A={1,3,5,7}, B={2,4,6,8}, o_rdy=1 → o_data 1..8 on consecutive cycles; o_last only with 8; run_cnt=1.
- A={1,2,3,4}, B={5,6,7,8} → enters DRAIN_B after key 4; output 1..8 in order; b_rdy=0 throughout MERGE.
- Ties: A={2,2,2,2}, B={2,2,2,2}, with tags in the upper bits equal → all four A keys precede the B keys.
- o_rdy toggling 1/0 every cycle, plus b_vld gaps during MERGE → no loss or duplication; output held during stalls; 8 keys in order.
- Reset asserted after 3 outputs, then a fresh pair applied → o_vld=0 during reset; the new pair merges correctly; run_cnt counts only the completed pair.
- HAMS_MERGE_DESC_EN defined, A={9,7,5,3}, B={8,6,4,2} → output 9,8,7,...,2; o_last with 2.
